// File: rtl/blink_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : blink_pkg
//  Description: Shared types and constants for the button conditioning path.
//               Holds the debounce FSM state type, default timing constants
//               and a small elaboration-time helper.
//  Revision   : 1.0 - initial release
// ============================================================================
package blink_pkg;

   // Debounce FSM states
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   // 10 ms of stable input at a 100 MHz board clock
   localparam int DEBOUNCE_100MHZ_10MS = 1_000_000;
   // 500 ms auto-repeat period at a 100 MHz board clock
   localparam int REPEAT_100MHZ_500MS  = 50_000_000;

   // Larger of two integers, used to size shared counters at elaboration
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage : blink_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module     : sync_2ff
//  Description: Two-flop synchroniser bringing an asynchronous 1-bit input
//               into the clk domain. Reusable for buttons and switches.
//  Revision   : 1.0 - initial release
// ============================================================================
module sync_2ff (
   input  logic clk,
   input  logic reset,   // asynchronous, active-low
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_sync;

   // First flop may go metastable; second flop gives it a full cycle to settle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module     : btn_debounce
//  Description: Push-button conditioner. Synchronises the raw button, rejects
//               bounce with a stable-time counter, and produces a clean level
//               plus one-cycle press and release strobes.
//               Optional feature macro: BTN_AUTOREPEAT_EN - while the button
//               stays held, re-emit btn_pulse every REPEAT_CYCLES cycles.
//  Revision   : 1.0 - initial release
// ============================================================================
module btn_debounce
   import blink_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ_10MS,
   parameter int REPEAT_CYCLES   = REPEAT_100MHZ_500MS
) (
   input  logic clk,
   input  logic reset,        // asynchronous, active-low
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_pulse,
   output logic btn_release
);

   // Shared width for the debounce and repeat counters
   localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, REPEAT_CYCLES) + 1);

   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] c_RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

   logic             w_s;
   btn_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_pulse;
   logic             r_release;
`ifdef BTN_AUTOREPEAT_EN
   logic [CNT_W-1:0] r_rpt;
`endif

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (btn_raw),
      .q     (w_s)
   );

   // Debounce FSM: a level change is accepted only after the synchronised
   // input has stayed at the new value for the full debounce window
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_pulse   <= 1'b0;
         r_release <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         r_rpt     <= '0;
`endif
      end else begin
         // Strobes default low so each one lasts exactly one cycle
         r_pulse   <= 1'b0;
         r_release <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_s) begin
                  r_state <= PRESS_WAIT;
                  r_cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!w_s) begin
                  r_state <= IDLE;
               end else if (r_cnt == c_DEB_LAST) begin
                  r_state <= HELD;
                  r_level <= 1'b1;
                  r_pulse <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                  r_rpt   <= '0;
`endif
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            HELD: begin
               if (!w_s) begin
                  // Repeat counter is left frozen while the release is judged
                  r_state <= RELEASE_WAIT;
                  r_cnt   <= '0;
               end
`ifdef BTN_AUTOREPEAT_EN
               else if (r_rpt == c_RPT_LAST) begin
                  r_pulse <= 1'b1;
                  r_rpt   <= '0;
               end else begin
                  r_rpt <= r_rpt + c_CNT_ONE;
               end
`endif
            end
            RELEASE_WAIT: begin
               if (w_s) begin
                  // Release was a glitch: back to held without a new press
                  r_state <= HELD;
`ifdef BTN_AUTOREPEAT_EN
                  r_rpt   <= '0;
`endif
               end else if (r_cnt == c_DEB_LAST) begin
                  r_state   <= IDLE;
                  r_level   <= 1'b0;
                  r_release <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign btn_level   = r_level;
   assign btn_pulse   = r_pulse;
   assign btn_release = r_release;

endmodule : btn_debounce
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module     : tb_btn_debounce
//  Description: Self-checking bench for btn_debounce (DEBOUNCE_CYCLES=4,
//               REPEAT_CYCLES=8). Directed tables and sequences plus random
//               bursts checked against a run-length reference model.
//               Honours BTN_AUTOREPEAT_EN when defined.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_btn_debounce;

   localparam int D = 4;
   localparam int R = 8;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic btn_raw = 1'b0;
   logic btn_level;
   logic btn_pulse;
   logic btn_release;

   int n_tests = 0;
   int n_fail  = 0;

   btn_debounce #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_CYCLES   (R)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_pulse   (btn_pulse),
      .btn_release (btn_release)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // The FSM sees the raw input two edges late. A level change is accepted
   // once D+1 consecutive FSM samples disagree with the current level.
   bit hist[$];
   bit m_level, m_pulse, m_release;
   int m_run;   // consecutive samples disagreeing with m_level
   int m_age;   // held samples since last (re)entry into the held condition

   function automatic void model_reset();
      hist      = '{1'b0, 1'b0};
      m_level   = 1'b0;
      m_pulse   = 1'b0;
      m_release = 1'b0;
      m_run     = 0;
      m_age     = 0;
   endfunction

   function automatic void model_edge(input bit raw, input bit rst_n);
      bit s;
      if (!rst_n) begin
         model_reset();
         return;
      end
      s = hist[0];
      hist.push_back(raw);
      void'(hist.pop_front());
      m_pulse   = 1'b0;
      m_release = 1'b0;
      if (s != m_level) begin
         m_run++;
         if (m_run == D + 1) begin
            m_level = s;
            m_run   = 0;
            if (s) begin
               m_pulse = 1'b1;
               m_age   = 0;
            end else begin
               m_release = 1'b1;
            end
         end
      end else begin
         if (m_level && m_run > 0) begin
            m_age = 0;
         end else if (m_level && AR) begin
            m_age++;
            if (m_age == R) begin
               m_pulse = 1'b1;
               m_age   = 0;
            end
         end
         m_run = 0;
      end
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".level"},   {31'd0, btn_level},   {31'd0, m_level});
      check({tag, ".pulse"},   {31'd0, btn_pulse},   {31'd0, m_pulse});
      check({tag, ".release"}, {31'd0, btn_release}, {31'd0, m_release});
   endtask

   // Drive raw, take one edge, sample 1 ns later, compare with the model
   task automatic tick(input logic raw);
      btn_raw = raw;
      @(posedge clk);
      #1;
      model_edge(raw, reset);
      check_model("model");
   endtask

   // Hold the current raw value and count edges until the selected strobe
   task automatic measure(input bit want_release, output int n);
      n = -1;
      for (int i = 1; i <= 20; i++) begin
         tick(btn_raw);
         if ((want_release ? btn_release : btn_pulse) === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   typedef struct {
      logic raw;
      logic lvl;
      logic pls;
      logic rel;
   } vec_t;

   vec_t t1[12];
   int   offs[$];
   int   exp_offs[$];
   int   n;
   int   seg_len;
   logic seg_val;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Clean press table: raw first sampled high at edge 2, accepted at edge 8
      for (int i = 0; i < 12; i++) begin
         t1[i].raw = (i >= 2);
         t1[i].lvl = (i >= 8);
         t1[i].pls = (i == 8);
         t1[i].rel = 1'b0;
      end
`ifdef BTN_AUTOREPEAT_EN
      exp_offs = '{8, 16, 24};
`endif

      // ---- reset state ----
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset.level",   {31'd0, btn_level},   32'd0);
      check("reset.pulse",   {31'd0, btn_pulse},   32'd0);
      check("reset.release", {31'd0, btn_release}, 32'd0);
      reset = 1'b1;

      // ---- 1. clean press (table-driven) ----
      for (int i = 0; i < 12; i++) begin
         tick(t1[i].raw);
         check($sformatf("t1[%0d].level", i),   {31'd0, btn_level},   {31'd0, t1[i].lvl});
         check($sformatf("t1[%0d].pulse", i),   {31'd0, btn_pulse},   {31'd0, t1[i].pls});
         check($sformatf("t1[%0d].release", i), {31'd0, btn_release}, {31'd0, t1[i].rel});
      end

      // ---- 3. release glitch while held: 2 low, then high ----
      for (int i = 0; i < 9; i++) begin
         tick((i < 2) ? 1'b0 : 1'b1);
         check("glitch.level",   {31'd0, btn_level},   32'd1);
         check("glitch.pulse",   {31'd0, btn_pulse},   32'd0);
         check("glitch.release", {31'd0, btn_release}, 32'd0);
      end

      // ---- 6. long hold: re-entry to held was 4 edges ago ----
      for (int t = 5; t <= 30; t++) begin
         tick(1'b1);
         if (btn_pulse === 1'b1) offs.push_back(t);
      end
      check("repeat.count", offs.size(), exp_offs.size());
      foreach (exp_offs[i]) begin
         if (i < offs.size()) check($sformatf("repeat.off%0d", i), offs[i], exp_offs[i]);
      end

      // ---- 4. full release ----
      tick(1'b0);
      measure(1'b1, n);
      check("release.latency", n, 32'd6);
      check("release.level",   {31'd0, btn_level}, 32'd0);
      tick(1'b0);
      check("release.width",   {31'd0, btn_release}, 32'd0);
      repeat (3) tick(1'b0);

      // ---- 2. bounce before a press ----
      tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);
      check("bounce.pulse", {31'd0, btn_pulse}, 32'd0);
      tick(1'b1);
      measure(1'b0, n);
      check("bounce.latency", n, 32'd6);
      check("bounce.level",   {31'd0, btn_level}, 32'd1);

      // ---- 5. reset in the middle of the press wait ----
      tick(1'b0);
      measure(1'b1, n);
      check("rel2.latency", n, 32'd6);
      repeat (3) tick(1'b0);
      repeat (5) tick(1'b1);   // press wait with count at 2
      reset = 1'b0;
      #1;
      model_reset();
      check("midreset.level",   {31'd0, btn_level},   32'd0);
      check("midreset.pulse",   {31'd0, btn_pulse},   32'd0);
      check("midreset.release", {31'd0, btn_release}, 32'd0);
      tick(1'b1);
      check("inreset.pulse", {31'd0, btn_pulse}, 32'd0);
      reset = 1'b1;
      tick(1'b1);              // first post-reset sample
      measure(1'b0, n);
      check("postreset.latency", n, 32'd6);

      // ---- random bursts against the model ----
      for (int seg = 0; seg < 60; seg++) begin
         seg_val = 1'($urandom_range(0, 1));
         seg_len = $urandom_range(1, 12);
         if ($urandom_range(0, 19) == 0) begin
            reset = 1'b0;
            #1;
            model_reset();
            check_model("rnd_reset");
            tick(seg_val);
            reset = 1'b1;
         end
         for (int j = 0; j < seg_len; j++) tick(seg_val);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_btn_debounce
`default_nettype wire
